// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
//
// Sequential AES InvSubBytes engine. A 128-bit state is accepted over a
// valid/ready handshake, every byte is replaced by its inverse S-box value,
// BYTES_PER_CYCLE bytes per clock, and the result is offered over a second
// valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_state carries a state to be substituted
//   in_ready   engine accepts a state this cycle (IDLE, or DONE with out_ready)
//   in_state   input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  out_state holds a completed result
//   out_ready  downstream accepts out_state
//   out_state  substituted state, same byte ordering
//   busy       engine is in RUN or DONE
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Only divisors of 16 that are powers of two are meaningful group sizes.
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // For 16 lanes the step truncates to 0, which is exactly the wrap we want.
    localparam logic [3:0] IDX_STEP = 4'(BYTES_PER_CYCLE);
    localparam logic [3:0] LAST_IDX = 4'(16 - BYTES_PER_CYCLE);

    state_t       state_r;
    state_t       state_s;
    logic [3:0]   idx_r;
    logic [3:0]   idx_s;
    logic [127:0] work_r;
    logic [127:0] work_s;

    // GF(2^8) multiply modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // InvSBox lookup: undo the forward affine map, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Next-state logic: handshake acceptance, per-group substitution, hand-off.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        work_s  = work_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    work_s  = in_state;
                    idx_s   = 4'd0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                    logic [3:0] pos;
                    logic [6:0] base;
                    pos  = idx_r + 4'(l);
                    // Byte k lives at bit 8*(15-k); 15-k in 4 bits is ~k.
                    base = {~pos, 3'b000};
                    work_s[base +: 8] = inv_sbox(work_r[base +: 8]);
                end
                idx_s = idx_r + IDX_STEP;
                if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        work_s  = in_state;
                        idx_s   = 4'd0;
                        state_s = RUN;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 4'd0;
                work_s  = 128'd0;
            end
        endcase
    end

    // State, index and working register; reset discards any in-flight state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= 4'd0;
            work_r  <= 128'd0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            work_r  <= work_s;
        end
    end

    assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign out_valid = (state_r == DONE);
    assign out_state = work_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_bytes_seq
//
// Directed bench for inv_sub_bytes_seq. Five instances (1, 2, 4, 8, 16 lanes)
// share the input side; instance 2 (4 lanes) is the main one for most checks.
// -----------------------------------------------------------------------------
module tb_inv_sub_bytes_seq;

    localparam int NW = 5;
    localparam int MAIN = 2;
    localparam logic [127:0] C1_IN     = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] C1_OUT    = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ANCH_IN   = 128'h637c00ed1652637c00ed1652637c00ed;
    localparam logic [127:0] ANCH_OUT  = 128'h00015253ff4800015253ff4800015253;
    localparam logic [127:0] ZERO_OUT  = {16{8'h52}};

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;
    logic         ir [NW];
    logic         ov [NW];
    logic         bz [NW];
    logic [127:0] os [NW];

    int checks;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NW; g++) begin : g_dut
        inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_state  (in_state),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_state (os[g]),
            .busy      (bz[g])
        );
    end

    // Forward S-box, used only to build stimulus for the full-table sweep.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        pw = inv;
        return pw ^ {pw[6:0], pw[7]} ^ {pw[5:0], pw[7:6]} ^ {pw[4:0], pw[7:5]}
                  ^ {pw[3:0], pw[7:4]} ^ 8'h63;
    endfunction

    task automatic run_one(input logic [127:0] st, output logic [127:0] res, output int lat);
        int w;
        lat = -1;
        res = 128'd0;
        w = 0;
        while (!ir[MAIN] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        in_state = st;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
        w = 0;
        while (!ov[MAIN] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (ov[MAIN]) begin
            lat = w;
            res = os[MAIN];
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_state = 128'd0;
        #1 rst_n = 1'b0;
        #11;
        checks++;
        if (ov[MAIN] !== 1'b0 || bz[MAIN] !== 1'b0 || os[MAIN] !== 128'd0) begin
            fails++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b out_state=%h, required 0 0 0",
                     ov[MAIN], bz[MAIN], os[MAIN]);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ir[MAIN] !== 1'b1 || bz[MAIN] !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", ir[MAIN], bz[MAIN]);
        end
    endtask

    task automatic test_widths;
        int lat [NW];
        for (int g = 0; g < NW; g++) lat[g] = 0;
        in_state = C1_IN;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = 128'd0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < NW; g++) begin
                if (ov[g] && lat[g] == 0) lat[g] = c;
            end
        end
        for (int g = 0; g < NW; g++) begin
            checks++;
            if (lat[g] !== (16 >> g)) begin
                fails++;
                $display("FAIL width_latency bpc=%0d: latency %0d, required %0d", 1 << g, lat[g], 16 >> g);
            end
            checks++;
            if (os[g] !== C1_OUT) begin
                fails++;
                $display("FAIL width_c1 bpc=%0d: out_state %h, required %h", 1 << g, os[g], C1_OUT);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int g = 0; g < NW; g++) begin
            checks++;
            if (ov[g] !== 1'b0 || bz[g] !== 1'b0) begin
                fails++;
                $display("FAIL width_drain bpc=%0d: out_valid=%b busy=%b, required 0 0", 1 << g, ov[g], bz[g]);
            end
        end
    endtask

    task automatic test_zero;
        logic [127:0] res;
        int lat;
        run_one(128'd0, res, lat);
        checks++;
        if (lat !== 4 || res !== ZERO_OUT) begin
            fails++;
            $display("FAIL zero_state: latency %0d out_state %h, required 4 %h", lat, res, ZERO_OUT);
        end
        checks++;
        if (bz[MAIN] !== 1'b0 || ov[MAIN] !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle: busy=%b out_valid=%b, required 0 0", bz[MAIN], ov[MAIN]);
        end
    endtask

    task automatic test_anchors;
        logic [127:0] res;
        int lat;
        run_one(ANCH_IN, res, lat);
        checks++;
        if (lat !== 4 || res !== ANCH_OUT) begin
            fails++;
            $display("FAIL anchors: latency %0d out_state %h, required 4 %h", lat, res, ANCH_OUT);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        in_state = 128'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (bz[MAIN] !== 1'b1 || ov[MAIN] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_run_busy: busy=%b out_valid=%b, required 1 0", bz[MAIN], ov[MAIN]);
        end
        w = 0;
        while (!ov[MAIN] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        for (int c = 0; c < 10; c++) begin
            in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid = 1'b1;
            #1;
            checks++;
            if (ov[MAIN] !== 1'b1 || os[MAIN] !== ZERO_OUT || ir[MAIN] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_hold cycle %0d: out_valid=%b in_ready=%b out_state=%h, required 1 0 %h",
                         c, ov[MAIN], ir[MAIN], os[MAIN], ZERO_OUT);
            end
            @(posedge clk); #1;
        end
        in_state = C1_IN;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir[MAIN] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_ready: in_ready=%b, required 1", ir[MAIN]);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_state = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        checks++;
        if (bz[MAIN] !== 1'b1 || ov[MAIN] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_idle: busy=%b out_valid=%b, required 1 0", bz[MAIN], ov[MAIN]);
        end
        w = 0;
        while (!ov[MAIN] && w < 50) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (w !== 4 || os[MAIN] !== C1_OUT) begin
            fails++;
            $display("FAIL b2b_second: latency %0d out_state %h, required 4 %h", w, os[MAIN], C1_OUT);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_all_bytes;
        logic [127:0] st;
        logic [127:0] expv;
        logic [127:0] res;
        logic [7:0] b;
        int lat;
        for (int x = 0; x < 256; x++) begin
            for (int k = 0; k < 16; k++) begin
                b = 8'(x + k);
                st[8*(15-k) +: 8] = fwd_sbox(b);
                expv[8*(15-k) +: 8] = b;
            end
            run_one(st, res, lat);
            checks++;
            if (lat !== 4 || res !== expv) begin
                fails++;
                $display("FAIL all_bytes x=%02h: latency %0d out_state %h, required 4 %h", x, lat, res, expv);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic [127:0] res;
        int lat;
        in_state = C1_IN;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[MAIN] !== 1'b0 || os[MAIN] !== 128'd0 || bz[MAIN] !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: out_valid=%b busy=%b out_state=%h, required 0 0 0",
                     ov[MAIN], bz[MAIN], os[MAIN]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ir[MAIN] !== 1'b1 || bz[MAIN] !== 1'b0 || ov[MAIN] !== 1'b0) begin
            fails++;
            $display("FAIL midrun_idle: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
                     ir[MAIN], bz[MAIN], ov[MAIN]);
        end
        run_one({16{8'h63}}, res, lat);
        checks++;
        if (lat !== 4 || res !== 128'd0) begin
            fails++;
            $display("FAIL midrun_next: latency %0d out_state %h, required 4 0", lat, res);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        test_reset();
        test_widths();
        test_zero();
        test_anchors();
        test_back_to_back();
        test_all_bytes();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential AES InvSubBytes engine for the decryption datapath. It accepts one 128-bit AES state over a valid/ready handshake and replaces every byte with its inverse S-box value, BYTES_PER_CYCLE bytes per clock. It returns the result over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse round, and is the decrypt-side counterpart of the forward S-box substitution.

## Interface
- BYTES_PER_CYCLE, 4, bytes substituted per RUN cycle; legal values 1, 2, 4, 8, 16; others are a elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  engine can accept a state this cycle.
- in_state  input  128  ciphertext-side state; byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  substituted state, same byte ordering.
- busy  output  1  high in RUN or DONE.

## Operation
- InvSBox is the exact inverse of the AES forward S-box: InvSBox(SBox(x)) = x for all 256 x. Anchor values: 63→00, 7c→01, 00→52, ed→53, 16→ff, 52→48.
- Each substitution lane holds an internal 256-entry InvSBox lookup. There are BYTES_PER_CYCLE lanes.
- There is one 128-bit working register and a 4-bit byte index idx.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, the working register loads in_state, idx is set to 0, and the FSM goes to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, bytes idx..idx+BYTES_PER_CYCLE-1 of the working register are replaced by InvSBox of themselves.
  - idx then advances by BYTES_PER_CYCLE, using 4-bit arithmetic that wraps to 0 after the last group.
  - Only the addressed bytes change; all other bytes hold.
  - On the cycle that processes the group ending at byte 15, the FSM goes to DONE.
- DONE:
  - out_valid=1 and out_state = working register.
  - Both stay stable until out_ready is sampled high.
  - On out_ready, the FSM goes to IDLE.
  - Back-to-back: in_ready = out_ready while in DONE. If in_valid is also high, the new state is loaded, idx is set to 0, and the FSM goes directly to RUN, skipping IDLE.
- in_state is sampled only at the accepting edge. Changes at any other time are ignored.
- out_valid never drops without out_ready.

## Timing
- Reset values (immediate on rst_n low, independent of clk):
  - FSM = IDLE, idx = 0.
  - out_valid = 0, busy = 0, out_state = 0.
  - in_ready = 1 once reset deasserts.
- Reset mid-RUN or mid-DONE discards the in-flight state; no partial result is ever presented.
- Let N = 16/BYTES_PER_CYCLE.
- Latency: if a state is accepted at edge E0, out_valid is high from edge E0+N onward.
- Throughput: one result per N+1 cycles with out_ready tied high.
- in_ready is combinational from FSM state and out_ready only, never from in_valid.
- in_ready and out_valid are never both high without out_ready also being high.

## Test plan
- Reset, then all-zero in_state with BYTES_PER_CYCLE=4 → out_valid rises exactly 4 cycles after acceptance, out_state = 0x52 repeated 16 times; busy is high during RUN/DONE.
- FIPS-197 C.1 inverse round 1, with in_state = 7a9f102789d5f50b2beffd9f3dca4ea7 → out_state = bd6e7c3df2b5779e0b61216e8b10b689. Run for BYTES_PER_CYCLE = 1, 2, 4, 8, 16; required latencies are 16, 8, 4, 2, 1.
- All 256 byte values, with in_state built from the forward S-box of x, x+1, …, x+15 → out_state = x..x+15 for every x. Covers full-table inversion and idx wrap.
- out_ready held low for 10 cycles in DONE → out_valid and out_state stay stable, in_ready = 0, and in_state changes are ignored. Releasing out_ready with in_valid high → the next state is accepted on the same edge, with no IDLE cycle.
- rst_n pulsed low mid-RUN (idx = 8) → out_valid = 0, out_state = 0, and the FSM returns to IDLE. The next accepted all-0x63 state → out_state = all 0x00 with normal latency.
